// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM arbiter: default bus widths and FSM state encoding.
// Latency: none (package only).
// Backpressure: none (package only).
package sram_arb_pkg;

  localparam int AW_DEF = 18;
  localparam int DW_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester ports A/B, the SRAM controller side and the busy flag.
// Latency: none (wires only).
// Backpressure: requesters hold x_req and the command fields until x_ack.
interface sram_arbiter_if #(
  parameter int AW = sram_arb_pkg::AW_DEF,
  parameter int DW = sram_arb_pkg::DW_DEF
);

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic          a_err;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic          b_err;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  // Arbiter side: serves the two requesters and drives the SRAM controller.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_ready, mem_rdata,
    output busy
  );

  // Environment side: requesters plus SRAM controller.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_ready, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port (A=CPU, B=DMA) arbiter in front of a single SRAM controller, A-priority with a B starvation limit.
// Latency: req seen in cycle 0, mem_ready in cycle k (k>=2) -> x_ack in cycle k+1; next grant at k+2.
// Backpressure: one transfer in flight; requests are only sampled in IDLE and must be held until x_ack.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input logic          CLK0,
  input logic          reset_n,
  sram_arbiter_if.slave bus
);

  // Streak counter is at least 3 bits wide; wait counter must reach TIMEOUT-1.
  localparam int SW_RAW = $clog2(MAX_BURST + 1);
  localparam int SW     = (SW_RAW < 3) ? 3 : SW_RAW;
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  state_t        state_q,     state_d;
  logic [SW-1:0] streak_q,    streak_d;
  logic [CW-1:0] wcnt_q,      wcnt_d;
  logic          gnt_b_q,     gnt_b_d;
  logic          we_q,        we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q,    mem_rd_d;
  logic          mem_wr_q,    mem_wr_d;
  logic          a_ack_q,     a_ack_d;
  logic          b_ack_q,     b_ack_d;
  logic          a_err_q,     a_err_d;
  logic          b_err_q,     b_err_d;
  logic [DW-1:0] a_rdata_q,   a_rdata_d;
  logic [DW-1:0] b_rdata_q,   b_rdata_d;

  logic          pick_b;
  logic          win_we;

  // Next-state logic: arbitration in IDLE, one-cycle strobe in ISSUE, completion/timeout in WAIT.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wcnt_d      = wcnt_q;
    gnt_b_d     = gnt_b_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    // B wins when alone, or when A has used up its streak while B was waiting.
    pick_b      = bus.b_req && (!bus.a_req || (streak_q == SW'(MAX_BURST)));
    win_we      = pick_b ? bus.b_we : bus.a_we;

    case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          gnt_b_d     = pick_b;
          we_d        = win_we;
          mem_addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
          mem_wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
          // The strobe flop is loaded here so it is high for exactly the ISSUE cycle.
          mem_rd_d    = !win_we;
          mem_wr_d    = win_we;
          wcnt_d      = '0;
          if (pick_b || !bus.b_req) begin
            streak_d = '0;
          end else begin
            streak_d = streak_q + SW'(1);
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.mem_ready) begin
          if (gnt_b_q) begin
            b_ack_d = 1'b1;
            if (!we_q) b_rdata_d = bus.mem_rdata;
          end else begin
            a_ack_d = 1'b1;
            if (!we_q) a_rdata_d = bus.mem_rdata;
          end
          state_d = ST_DONE;
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          // Controller never answered: abort with error and zeroed read data.
          if (gnt_b_q) begin
            b_ack_d   = 1'b1;
            b_err_d   = 1'b1;
            b_rdata_d = '0;
          end else begin
            a_ack_d   = 1'b1;
            a_err_d   = 1'b1;
            a_rdata_d = '0;
          end
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any in-flight transfer.
  always_ff @(posedge CLK0) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      wcnt_q      <= '0;
      gnt_b_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wcnt_q      <= wcnt_d;
      gnt_b_q     <= gnt_b_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_err     = a_err_q;
  assign bus.b_err     = b_err_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: read latency, grant fairness, write, timeout, reset abort, stray mem_ready.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sram_arbiter;

  logic CLK0;
  logic reset_n;

  int checks   = 0;
  int failures = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int overlap   = 0;
  int rd_base;
  int wr_base;

  sram_arbiter_if #(.AW(18), .DW(16)) bus();

  sram_arbiter #(.AW(18), .DW(16), .MAX_BURST(4), .TIMEOUT(15)) dut (
    .CLK0    (CLK0),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial CLK0 = 1'b0;
  always #5 CLK0 = ~CLK0;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge CLK0) begin
    if (bus.mem_rd) rd_pulses++;
    if (bus.mem_wr) wr_pulses++;
    if (bus.mem_rd && bus.mem_wr) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (3) tick();
    reset_n = 1;
  endtask

  logic [1:0] exp_order [10];

  initial begin
    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b10; exp_order[3] = 2'b10;
    exp_order[4] = 2'b01; exp_order[5] = 2'b10; exp_order[6] = 2'b10; exp_order[7] = 2'b10;
    exp_order[8] = 2'b10; exp_order[9] = 2'b01;

    do_reset();
    // Reset state
    chk("rst_busy",  {31'b0, bus.busy},   0);
    chk("rst_rdwr",  {30'b0, bus.mem_rd, bus.mem_wr}, 0);
    chk("rst_acks",  {28'b0, bus.a_ack, bus.b_ack, bus.a_err, bus.b_err}, 0);
    chk("rst_addr",  {14'b0, bus.mem_addr}, 0);
    chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);

    // A read, addr 0x00123, mem_ready at k=2
    rd_base = rd_pulses;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 18'h00123;       // cycle 0
    tick();                                                     // cycle 1
    chk("t1_rd_c1",   {31'b0, bus.mem_rd}, 1);
    chk("t1_wr_c1",   {31'b0, bus.mem_wr}, 0);
    chk("t1_addr",    {14'b0, bus.mem_addr}, 32'h00123);
    chk("t1_busy",    {31'b0, bus.busy}, 1);
    tick();                                                     // cycle 2
    chk("t1_rd_c2",   {31'b0, bus.mem_rd}, 0);
    chk("t1_ack_c2",  {31'b0, bus.a_ack}, 0);
    bus.mem_ready = 1; bus.mem_rdata = 16'h00A5;
    tick();                                                     // cycle 3
    chk("t1_ack_c3",  {30'b0, bus.a_ack, bus.b_ack}, 2'b10);
    chk("t1_err",     {31'b0, bus.a_err}, 0);
    chk("t1_rdata",   {16'b0, bus.a_rdata}, 32'h00A5);
    bus.mem_ready = 0; bus.a_req = 0;
    tick();                                                     // cycle 4
    chk("t1_ack_c4",  {31'b0, bus.a_ack}, 0);
    chk("t1_idle",    {31'b0, bus.busy}, 0);
    chk("t1_hold",    {16'b0, bus.a_rdata}, 32'h00A5);
    chk("t1_rd_cnt",  rd_pulses - rd_base, 1);

    // Timeout: mem_ready never comes
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 18'h00ABC;        // cycle 0
    tick();                                                     // cycle 1 (ISSUE)
    for (int i = 2; i <= 16; i++) tick();                       // cycles 2..16 WAIT
    chk("to_c16_ack", {31'b0, bus.a_ack}, 0);
    chk("to_c16_busy",{31'b0, bus.busy}, 1);
    tick();                                                     // cycle 17 DONE
    chk("to_ack",     {30'b0, bus.a_ack, bus.a_err}, 2'b11);
    chk("to_rdata",   {16'b0, bus.a_rdata}, 0);
    chk("to_no_b",    {30'b0, bus.b_ack, bus.b_err}, 0);
    bus.a_req = 0;
    tick();                                                     // cycle 18 IDLE
    chk("to_idle",    {30'b0, bus.busy, bus.a_err}, 0);

    // Fairness with both requesting continuously
    do_reset();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 18'h00010;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 18'h00020;
    for (int t = 0; t < 10; t++) begin
      tick();                                                   // ISSUE
      tick();                                                   // WAIT
      bus.mem_ready = 1; bus.mem_rdata = 16'(t);
      tick();                                                   // DONE
      chk($sformatf("order_%0d", t), {30'b0, bus.a_ack, bus.b_ack}, {30'b0, exp_order[t]});
      bus.mem_ready = 0;
      tick();                                                   // IDLE
    end
    chk("order_brdata", {16'b0, bus.b_rdata}, 9);
    chk("order_ardata", {16'b0, bus.a_rdata}, 8);
    bus.a_req = 0; bus.b_req = 0;

    // B write, addr 0x3FFFF, wdata 0xBEEF
    do_reset();
    wr_base = wr_pulses;
    rd_base = rd_pulses;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 18'h3FFFF; bus.b_wdata = 16'hBEEF;
    tick();                                                     // cycle 1
    chk("bw_wr",      {30'b0, bus.mem_wr, bus.mem_rd}, 2'b10);
    chk("bw_addr",    {14'b0, bus.mem_addr}, 32'h3FFFF);
    chk("bw_wdata",   {16'b0, bus.mem_wdata}, 32'hBEEF);
    tick();                                                     // cycle 2
    bus.mem_ready = 1;
    tick();                                                     // cycle 3
    chk("bw_ack",     {30'b0, bus.a_ack, bus.b_ack}, 2'b01);
    chk("bw_err",     {31'b0, bus.b_err}, 0);
    chk("bw_addr_hold", {14'b0, bus.mem_addr}, 32'h3FFFF);
    chk("bw_wdata_hold",{16'b0, bus.mem_wdata}, 32'hBEEF);
    bus.mem_ready = 0; bus.b_req = 0;
    tick();
    chk("bw_wr_cnt",  wr_pulses - wr_base, 1);
    chk("bw_rd_cnt",  rd_pulses - rd_base, 0);

    // Reset during WAIT, then a late mem_ready
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 18'h00077;
    tick();                                                     // ISSUE
    tick();                                                     // WAIT
    tick();                                                     // WAIT
    chk("rw_busy_pre", {31'b0, bus.busy}, 1);
    reset_n = 0; bus.a_req = 0;
    tick();
    chk("rw_busy_rst", {31'b0, bus.busy}, 0);
    chk("rw_ack_rst",  {31'b0, bus.a_ack}, 0);
    chk("rw_addr_rst", {14'b0, bus.mem_addr}, 0);
    reset_n = 1; bus.mem_ready = 1; bus.mem_rdata = 16'hDEAD;
    tick();
    chk("rw_late1",    {30'b0, bus.a_ack, bus.busy}, 0);
    tick();
    chk("rw_late2",    {30'b0, bus.a_ack, bus.b_ack}, 0);
    chk("rw_rdata",    {16'b0, bus.a_rdata}, 0);
    bus.mem_ready = 0;
    bus.a_req = 1; bus.a_addr = 18'h00055;
    tick(); tick();
    bus.mem_ready = 1; bus.mem_rdata = 16'h5A5A;
    tick();
    chk("rw_next_ack", {30'b0, bus.a_ack, bus.a_err}, 2'b10);
    chk("rw_next_dat", {16'b0, bus.a_rdata}, 32'h5A5A);
    bus.mem_ready = 0; bus.a_req = 0;
    tick();

    // Stray mem_ready in IDLE and ISSUE is ignored
    tick();
    bus.mem_ready = 1; bus.mem_rdata = 16'h1111;                // IDLE with ready
    tick();
    chk("st_idle",     {30'b0, bus.busy, bus.a_ack}, 0);
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 18'h00200;        // cycle 0, ready still high
    tick();                                                     // cycle 1 ISSUE, ready high
    chk("st_issue",    {31'b0, bus.mem_rd}, 1);
    bus.mem_ready = 0;
    tick();                                                     // cycle 2 WAIT
    chk("st_wait_ack", {31'b0, bus.a_ack}, 0);
    tick();                                                     // cycle 3 WAIT
    chk("st_c3",       {30'b0, bus.a_ack, bus.busy}, 2'b01);
    bus.mem_ready = 1; bus.mem_rdata = 16'h1234;
    tick();                                                     // cycle 4 DONE
    chk("st_ack",      {30'b0, bus.a_ack, bus.a_err}, 2'b10);
    chk("st_rdata",    {16'b0, bus.a_rdata}, 32'h1234);
    bus.mem_ready = 0; bus.a_req = 0;
    tick();
    chk("st_idle_end", {31'b0, bus.busy}, 0);

    chk("no_overlap",  overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
